// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: IF/ID hazard control (stall, squash, bubble) with stall/flush statistics
module pipeline_stall_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        idflush,
    input  logic        forward,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    output logic        pc_write,
    output logic        pc_sel_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        idex_bubble,
    output logic        branch_fwd_sel,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events,
    output logic        stall_timeout
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] id_instr_q, id_instr_d, id_pc4_q, id_pc4_d;
    logic [4:0]  run_len_q, run_len_d;
    logic [15:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
    logic        stall_timeout_q, stall_timeout_d;
    logic        taken;

    // a stall masks the branch/jump because the branch operands are not yet valid
    assign taken          = ~stall & (branch_taken | jump);
    assign pc_write       = ~stall;
    assign pc_sel_target  = taken;
    assign idex_bubble    = stall | idflush;
    assign branch_fwd_sel = forward & ~stall;
    assign id_instr       = id_instr_q;
    assign id_pc4         = id_pc4_q;
    assign stall_cycles   = stall_cycles_q;
    assign flush_events   = flush_events_q;
    assign stall_timeout  = stall_timeout_q;

    // next state: every state leaves on the same stall/taken priority
    always_comb begin
        state_d         = stall ? STALL : (taken ? FLUSH : RUN);
        id_instr_d      = stall ? id_instr_q : (taken ? 32'h0 : if_instr);
        id_pc4_d        = stall ? id_pc4_q : (taken ? 32'h0 : if_pc4);
        run_len_d       = stall ? ((run_len_q == 5'd31) ? run_len_q : run_len_q + 5'd1) : 5'd0;
        stall_timeout_d = stall_timeout_q | (stall & (run_len_q == 5'd15));
        stall_cycles_d  = (stall & ~&stall_cycles_q) ? stall_cycles_q + 16'd1 : stall_cycles_q;
        flush_events_d  = (taken & ~&flush_events_q) ? flush_events_q + 16'd1 : flush_events_q;
    end

    // state registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            id_instr_q      <= 32'h0;
            id_pc4_q        <= 32'h0;
            run_len_q       <= 5'd0;
            stall_timeout_q <= 1'b0;
            stall_cycles_q  <= 16'h0;
            flush_events_q  <= 16'h0;
        end else begin
            state_q         <= state_d;
            id_instr_q      <= id_instr_d;
            id_pc4_q        <= id_pc4_d;
            run_len_q       <= run_len_d;
            stall_timeout_q <= stall_timeout_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_events_q  <= flush_events_d;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed checks of hazard control, counters and timeout
module tb_pipeline_stall_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, idflush = 1'b0, forward = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] if_instr = 32'h0, if_pc4 = 32'h0;
    logic        pc_write, pc_sel_target, idex_bubble, branch_fwd_sel, stall_timeout;
    logic [31:0] id_instr, id_pc4;
    logic [15:0] stall_cycles, flush_events;
    int          total = 0, passed = 0, failed = 0;

    pipeline_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .idflush(idflush), .forward(forward),
        .branch_taken(branch_taken), .jump(jump), .if_instr(if_instr), .if_pc4(if_pc4),
        .pc_write(pc_write), .pc_sel_target(pc_sel_target), .id_instr(id_instr), .id_pc4(id_pc4),
        .idex_bubble(idex_bubble), .branch_fwd_sel(branch_fwd_sel), .stall_cycles(stall_cycles),
        .flush_events(flush_events), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state and combinational pass-through under reset
        #1;
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        chk("rst_stall_cycles", {16'h0, stall_cycles}, 32'h0);
        chk("rst_flush_events", {16'h0, flush_events}, 32'h0);
        chk("rst_timeout", {31'h0, stall_timeout}, 32'h0);
        chk("rst_pc_write", {31'h0, pc_write}, 32'h1);
        stall = 1'b1; #1;
        chk("rst_pc_write_stall", {31'h0, pc_write}, 32'h0);
        chk("rst_bubble_stall", {31'h0, idex_bubble}, 32'h1);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // normal flow
        if_instr = 32'h8C010004; if_pc4 = 32'h4;
        @(negedge clk);
        chk("norm_id_instr", id_instr, 32'h8C010004);
        chk("norm_id_pc4", id_pc4, 32'h4);
        chk("norm_pc_write", {31'h0, pc_write}, 32'h1);
        chk("norm_state", {30'h0, dut.state_q}, 32'd0);
        // load-use stall for two cycles
        stall = 1'b1; if_instr = 32'hAAAA0001; if_pc4 = 32'h8; #1;
        chk("lu_pc_write_1", {31'h0, pc_write}, 32'h0);
        chk("lu_bubble_1", {31'h0, idex_bubble}, 32'h1);
        @(negedge clk);
        if_instr = 32'hBBBB0002; #1;
        chk("lu_hold_1", id_instr, 32'h8C010004);
        chk("lu_pc_write_2", {31'h0, pc_write}, 32'h0);
        chk("lu_bubble_2", {31'h0, idex_bubble}, 32'h1);
        chk("lu_state_stall", {30'h0, dut.state_q}, 32'd1);
        @(negedge clk);
        stall = 1'b0; if_instr = 32'hCCCC0003; if_pc4 = 32'h8;
        chk("lu_hold_2", id_instr, 32'h8C010004);
        chk("lu_pc4_hold", id_pc4, 32'h4);
        chk("lu_stall_cycles", {16'h0, stall_cycles}, 32'd2);
        @(negedge clk);
        chk("lu_state_run", {30'h0, dut.state_q}, 32'd0);
        chk("lu_resume", id_instr, 32'hCCCC0003);
        // taken branch squashes the fetch
        branch_taken = 1'b1; #1;
        chk("br_pc_sel", {31'h0, pc_sel_target}, 32'h1);
        @(negedge clk);
        branch_taken = 1'b0;
        chk("br_id_instr", id_instr, 32'h0);
        chk("br_id_pc4", id_pc4, 32'h0);
        chk("br_flush_events", {16'h0, flush_events}, 32'd1);
        chk("br_state_flush", {30'h0, dut.state_q}, 32'd2);
        @(negedge clk);
        chk("br_after_state", {30'h0, dut.state_q}, 32'd0);
        chk("br_after_instr", id_instr, 32'hCCCC0003);
        // stall beats branch
        stall = 1'b1; branch_taken = 1'b1; #1;
        chk("sb_pc_sel", {31'h0, pc_sel_target}, 32'h0);
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0;
        chk("sb_hold", id_instr, 32'hCCCC0003);
        chk("sb_flush_events", {16'h0, flush_events}, 32'd1);
        chk("sb_stall_cycles", {16'h0, stall_cycles}, 32'd3);
        // jump squashes as well
        jump = 1'b1; #1;
        chk("jp_pc_sel", {31'h0, pc_sel_target}, 32'h1);
        @(negedge clk);
        jump = 1'b0;
        chk("jp_id_instr", id_instr, 32'h0);
        chk("jp_flush_events", {16'h0, flush_events}, 32'd2);
        // idflush alone only bubbles ID/EX
        idflush = 1'b1; #1;
        chk("idf_bubble", {31'h0, idex_bubble}, 32'h1);
        chk("idf_pc_write", {31'h0, pc_write}, 32'h1);
        @(negedge clk);
        idflush = 1'b0;
        chk("idf_id_instr", id_instr, 32'hCCCC0003);
        chk("idf_state", {30'h0, dut.state_q}, 32'd0);
        // timeout on the 16th consecutive stalled edge
        stall = 1'b1;
        repeat (15) @(negedge clk);
        chk("to_not_yet", {31'h0, stall_timeout}, 32'h0);
        @(negedge clk);
        chk("to_set", {31'h0, stall_timeout}, 32'h1);
        chk("to_stall_cycles", {16'h0, stall_cycles}, 32'd19);
        stall = 1'b0;
        @(negedge clk);
        chk("to_sticky", {31'h0, stall_timeout}, 32'h1);
        // forwarding select
        forward = 1'b1; #1;
        chk("fwd_on", {31'h0, branch_fwd_sel}, 32'h1);
        stall = 1'b1; #1;
        chk("fwd_stalled", {31'h0, branch_fwd_sel}, 32'h0);
        stall = 1'b0; forward = 1'b0;
        // stall counter saturation
        @(negedge clk);
        force dut.stall_cycles_q = 16'hFFFF;
        #1 release dut.stall_cycles_q;
        #1 chk("sat_preload", {16'h0, stall_cycles}, 32'hFFFF);
        stall = 1'b1;
        @(negedge clk);
        chk("sat_hold", {16'h0, stall_cycles}, 32'hFFFF);
        // reset mid-stall abandons the held state
        if_instr = 32'h11112222;
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("mid_rst_instr", id_instr, 32'h0);
        chk("mid_rst_cycles", {16'h0, stall_cycles}, 32'h0);
        chk("mid_rst_timeout", {31'h0, stall_timeout}, 32'h0);
        chk("mid_rst_pc_write", {31'h0, pc_write}, 32'h0);
        stall = 1'b0; if_instr = 32'hDEADBEEF; if_pc4 = 32'h40;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_instr", id_instr, 32'hDEADBEEF);
        chk("post_rst_pc4", id_pc4, 32'h40);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL provide `rst_n`, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL provide `stall`, input, 1: load-use or branch-operand hazard request from the ID hazard detector.
REQ-004 SHALL provide `idflush`, input, 1: ID/EX control-zeroing request from the hazard detector.
REQ-005 SHALL provide `forward`, input, 1: branch comparator takes its operand from the MEM-stage result.
REQ-006 SHALL provide `branch_taken`, input, 1: beq/bne resolved taken in ID.
REQ-007 SHALL provide `jump`, input, 1: jump decoded in ID.
REQ-008 SHALL provide `if_instr`, input, 32: fetched instruction.
REQ-009 SHALL provide `if_pc4`, input, 32: PC+4 of the fetched instruction.
REQ-010 SHALL provide `pc_write`, output, 1: PC register load enable.
REQ-011 SHALL provide `pc_sel_target`, output, 1: PC loads the branch/jump target instead of PC+4.
REQ-012 SHALL provide `id_instr`, output, 32: IF/ID instruction register.
REQ-013 SHALL provide `id_pc4`, output, 32: IF/ID PC+4 register.
REQ-014 SHALL provide `idex_bubble`, output, 1: zero ID/EX control bits this cycle.
REQ-015 SHALL provide `branch_fwd_sel`, output, 1: comparator operand mux select.
REQ-016 SHALL provide `stall_cycles`, output, 16: saturating count of stalled cycles.
REQ-017 SHALL provide `flush_events`, output, 16: saturating count of taken-branch/jump flushes.
REQ-018 SHALL provide `stall_timeout`, output, 1: sticky error flag for an over-long stall.

Function
REQ-019 SHALL derive the control outputs combinationally from the current inputs and state:
- `pc_write = ~stall`
- `pc_sel_target = ~stall & (branch_taken | jump)`
- `idex_bubble = stall | idflush`
- `branch_fwd_sel = forward & ~stall`
REQ-020 SHALL give `stall` priority over `branch_taken` and `jump`: while `stall` = 1, the branch and jump inputs are ignored because the branch operands are not valid.
REQ-021 SHALL, on a rising edge with `stall` = 1, hold `id_instr` and `id_pc4` unchanged.
REQ-022 SHALL, on a rising edge with `stall` = 0 and (`branch_taken` | `jump`) = 1, load `id_instr` = 32'h0000_0000 (NOP) and `id_pc4` = 0, squashing the wrong-path fetch.
REQ-023 SHALL, on a rising edge otherwise, load `id_instr` = `if_instr` and `id_pc4` = `if_pc4`.
REQ-024 SHALL implement a three-state FSM, with a state update every edge:
- RUN → STALL on `stall`
- RUN → FLUSH on a taken branch or jump
- STALL stays on `stall`; → FLUSH on `~stall` & taken; → RUN otherwise
- FLUSH → STALL on `stall`; stays FLUSH on a taken branch or jump; → RUN otherwise
REQ-025 SHALL, with a 5-bit `run_len`, clear `run_len` to 0 on any edge where `stall` = 0.
REQ-026 SHALL, with `stall` = 1, increment `run_len`, saturating at 31.
REQ-027 SHALL set `stall_timeout` on the edge where `stall` = 1 and `run_len` = 15, i.e. the 16th consecutive stalled cycle.
REQ-028 SHALL keep `stall_timeout` set until reset.
REQ-029 SHALL increment `stall_cycles` by 1 on each edge with `stall` = 1, saturating at 16'hFFFF.
REQ-030 SHALL increment `flush_events` by 1 on each edge with REQ-022 true, saturating at 16'hFFFF.
REQ-031 SHALL use 16-bit unsigned arithmetic for all counters, with no wrap-around.
REQ-032 SHALL keep `idflush` without `stall` from affecting the IF/ID registers or the FSM; it drives only `idex_bubble`.

Reset
REQ-033 SHALL, when `rst_n` = 0, immediately force: `id_instr` = 0, `id_pc4` = 0, FSM = RUN, `run_len` = 0, `stall_cycles` = 0, `flush_events` = 0, `stall_timeout` = 0.
REQ-034 SHALL, under reset, let the combinational outputs follow their inputs.
REQ-035 SHALL, when reset is asserted mid-stall or mid-flush, abandon the held or squashed state without completing it.
REQ-036 SHALL resume normal IF/ID loading on the first rising edge after `rst_n` deasserts.

Verification
REQ-037 SHALL cover normal flow:
- Stimulus: `if_instr` = 0x8C010004 and `if_pc4` = 0x4, no hazards.
- Response: after one edge `id_instr` = 0x8C010004 and `id_pc4` = 0x4; `pc_write` = 1.
REQ-038 SHALL cover load-use:
- Stimulus: `stall` = 1 for 2 cycles while `if_instr` changes.
- Response: `id_instr` held; `pc_write` = 0 and `idex_bubble` = 1 for both cycles; `stall_cycles` = 2; FSM ends in RUN one edge after `stall` drops.
REQ-039 SHALL cover a taken branch:
- Stimulus: `branch_taken` = 1 for one cycle.
- Response: `pc_sel_target` = 1 that cycle; `id_instr` = 0 after the edge; `flush_events` = 1.
REQ-040 SHALL cover stall plus branch together:
- Stimulus: `stall` = 1 and `branch_taken` = 1 in the same cycle.
- Response: `pc_sel_target` = 0; `id_instr` held; `flush_events` unchanged.
REQ-041 SHALL cover the timeout:
- Stimulus: `stall` = 1 for 16 cycles.
- Response: `stall_timeout` = 1 after the 16th edge and still 1 after `stall` drops.
REQ-042 SHALL cover forwarding and saturation:
- Stimulus: `forward` = 1 with `stall` = 0, then with `stall` = 1.
- Response: `branch_fwd_sel` = 1 then 0.
- Stimulus: preload `stall_cycles` to 0xFFFF, then one stall cycle.
- Response: `stall_cycles` stays 0xFFFF.
